// File: rtl/rr_input_arbiter_pkg.sv
// Shared definitions for the packet round-robin input arbiter and the
// other blocks that rely on the same header/EOP control-word convention.
package rr_input_arbiter_pkg;

    localparam int NUM_INPUTS = 4;
    localparam int IDX_W      = $clog2(NUM_INPUTS);

    // A non-zero ctrl marks a module header (before data) or EOP (after data).
    // A zero ctrl marks a plain data word.
    localparam int CTRL_DATA = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

endpackage

// File: rtl/rr_input_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: the first set request after ptr, wrapping.
// Returns a one-hot grant and its index. Both are zero-valued when nothing requests.
module rr_priority_pick
    import rr_input_arbiter_pkg::*;
(
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic [NUM_INPUTS-1:0] gnt,
    output logic [IDX_W-1:0]      idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Offset NUM_INPUTS wraps back to ptr itself, so it is checked last.
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/rr_input_arbiter.sv
// Packet-level round-robin arbiter: grants one input queue from the first word to EOP
// and forwards that queue's words to the pipeline with zero latency.
module rr_input_arbiter
    import rr_input_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_req_0,
    input  logic                  in_req_1,
    input  logic                  in_req_2,
    input  logic                  in_req_3,
    input  logic [DATA_WIDTH-1:0] in_data_0,
    input  logic [DATA_WIDTH-1:0] in_data_1,
    input  logic [DATA_WIDTH-1:0] in_data_2,
    input  logic [DATA_WIDTH-1:0] in_data_3,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_0,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_1,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_2,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_3,
    input  logic                  in_wr_0,
    input  logic                  in_wr_1,
    input  logic                  in_wr_2,
    input  logic                  in_wr_3,
    output logic                  in_rdy_0,
    output logic                  in_rdy_1,
    output logic                  in_rdy_2,
    output logic                  in_rdy_3,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [NUM_INPUTS-1:0] pkt_grant
);

    logic [NUM_INPUTS-1:0]                 req_vec, wr_vec, rdy_vec;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_vec;
    logic [NUM_INPUTS-1:0][CTRL_WIDTH-1:0] ctrl_vec;

    assign req_vec  = {in_req_3, in_req_2, in_req_1, in_req_0};
    assign wr_vec   = {in_wr_3, in_wr_2, in_wr_1, in_wr_0};
    assign data_vec = {in_data_3, in_data_2, in_data_1, in_data_0};
    assign ctrl_vec = {in_ctrl_3, in_ctrl_2, in_ctrl_1, in_ctrl_0};

    state_t                state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_INPUTS-1:0] pick_gnt;
    logic [IDX_W-1:0]      pick_idx;

    rr_priority_pick u_pick (
        .req (req_vec),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // rr_ptr is loaded with the winner, so outside IDLE it also names the granted input.
    logic                  active, xfer;
    logic                  sel_wr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [CTRL_WIDTH-1:0] sel_ctrl;

    assign active   = (state == HDR) || (state == BODY);
    assign sel_wr   = wr_vec[rr_ptr];
    assign sel_data = data_vec[rr_ptr];
    assign sel_ctrl = ctrl_vec[rr_ptr];
    assign xfer     = active && sel_wr && out_rdy;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_rdy
        assign rdy_vec[i] = active && (rr_ptr == IDX_W'(i)) && out_rdy;
    end

    assign {in_rdy_3, in_rdy_2, in_rdy_1, in_rdy_0} = rdy_vec;

    assign out_wr   = xfer;
    assign out_data = active ? sel_data : '0;
    assign out_ctrl = active ? sel_ctrl : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= IDX_W'(NUM_INPUTS - 1);
            pkt_grant <= '0;
        end else begin
            pkt_grant <= '0;
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        rr_ptr    <= pick_idx;
                        pkt_grant <= pick_gnt;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (xfer && sel_ctrl == CTRL_WIDTH'(CTRL_DATA))
                        state <= BODY;
                end
                BODY: begin
                    if (xfer && sel_ctrl != CTRL_WIDTH'(CTRL_DATA))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
